// File: rtl/vga_timing.sv
// VGA raster generator: advances x/y on each pixel strobe and registers sync,
// active-video and line/frame start flags aligned with the presented coordinates.
module vga_timing #(
  parameter int H_ACT    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACT    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  output logic [CW-1:0] px_x,
  output logic [CW-1:0] px_y,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACT);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACT);
  localparam logic [CW-1:0] H_SYNC_S = CW'(H_ACT + H_FP);
  localparam logic [CW-1:0] H_SYNC_E = CW'(H_ACT + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SYNC_S = CW'(V_ACT + V_FP);
  localparam logic [CW-1:0] V_SYNC_E = CW'(V_ACT + V_FP + V_SYNC);

  logic [CW-1:0] nx, ny;
  logic          wrap_x, wrap_y;
  logic          hs_nx, vs_nx, act_nx;

  // Decode from the next coordinates so registered flags line up with px_x/px_y.
  always_comb begin
    wrap_x = (px_x == H_LAST);
    wrap_y = wrap_x && (px_y == V_LAST);
    nx     = wrap_x ? '0 : px_x + CW'(1);
    ny     = px_y;
    if (wrap_y)      ny = '0;
    else if (wrap_x) ny = px_y + CW'(1);
    hs_nx  = (nx >= H_SYNC_S && nx < H_SYNC_E) ? SYNC_POL : ~SYNC_POL;
    vs_nx  = (ny >= V_SYNC_S && ny < V_SYNC_E) ? SYNC_POL : ~SYNC_POL;
    act_nx = (nx < H_ACT_C) && (ny < V_ACT_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_x        <= '0;
      px_y        <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      active      <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        px_x        <= nx;
        px_y        <= ny;
        hsync       <= hs_nx;
        vsync       <= vs_nx;
        active      <= act_nx;
        line_start  <= wrap_x;
        frame_start <= wrap_y;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: default 640x480 raster for line-level timing, plus a tiny
// active-high-sync raster so whole frames fit in a short run.
module tb_vga_timing;

  logic clk = 1'b0;
  logic rst_n;
  logic pix_en;
  always #5 clk = ~clk;

  logic [9:0] x, y;
  logic hs, vs, act, ls, fs;
  logic [3:0] sx, sy;
  logic s_hs, s_vs, s_act, s_ls, s_fs;

  vga_timing dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .px_x(x), .px_y(y),
    .hsync(hs), .vsync(vs), .active(act), .line_start(ls), .frame_start(fs)
  );

  // 15 x 11 raster: hsync x=10..12, vsync y=7..8, active 8x6.
  vga_timing #(
    .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACT(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b1), .CW(4)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .px_x(sx), .px_y(sy),
    .hsync(s_hs), .vsync(s_vs), .active(s_act), .line_start(s_ls), .frame_start(s_fs)
  );

  int checks = 0, failures = 0;
  int cyc = 0, ls_d = 0, hs_low_d = 0;
  int s_ls_n = 0, s_fs_n = 0, s_hs_n = 0, s_vs_n = 0, s_act_n = 0;
  int last_fs = -1, fs_gap = 0;

  typedef struct {
    int adv;
    int x, y;
    int hs, act, ls;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input int actual, input int expv);
    checks++;
    if (actual !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, actual, expv);
    end
  endtask

  // Called at a negedge; drives pix_en for one clk and samples at the next negedge.
  task automatic tick(input bit en);
    pix_en = en;
    @(negedge clk);
    cyc++;
    if (ls) ls_d++;
    if (s_ls) s_ls_n++;
    if (s_fs) begin
      s_fs_n++;
      if (last_fs >= 0) fs_gap = cyc - last_fs;
      last_fs = cyc;
    end
    if (en) begin
      if (!hs) hs_low_d++;
      if (s_hs) s_hs_n++;
      if (s_vs) s_vs_n++;
      if (s_act) s_act_n++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pix_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pix_en = 1'b0;
  endtask

  initial begin
    tbl[0] = '{619, 639, 0, 1, 1, 0};
    tbl[1] = '{1,   640, 0, 1, 0, 0};
    tbl[2] = '{15,  655, 0, 1, 0, 0};
    tbl[3] = '{1,   656, 0, 0, 0, 0};
    tbl[4] = '{95,  751, 0, 0, 0, 0};
    tbl[5] = '{1,   752, 0, 1, 0, 0};
    tbl[6] = '{47,  799, 0, 1, 0, 0};
    tbl[7] = '{1,   0,   1, 1, 1, 1};

    // Reset state, pix_en high during reset must be ignored
    rst_n = 1'b0;
    pix_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_x", x, 0);       chk("rst_y", y, 0);
    chk("rst_hs", hs, 1);     chk("rst_vs", vs, 1);
    chk("rst_act", act, 1);   chk("rst_ls", ls, 0);   chk("rst_fs", fs, 0);
    chk("rst_s_hs", s_hs, 0); chk("rst_s_vs", s_vs, 0); chk("rst_s_act", s_act, 1);
    rst_n = 1'b1;
    pix_en = 1'b0;

    // No pulse on release, strobes every 4th clk
    tick(0); tick(0);
    chk("rel_ls", ls, 0); chk("rel_fs", fs, 0); chk("rel_x", x, 0);
    ls_d = 0;
    tick(1);
    chk("t1_first_x", x, 1);
    tick(0); tick(0); tick(0);
    chk("t1_hold_x", x, 1);
    for (int i = 1; i < 20; i++) begin
      tick(1); tick(0); tick(0); tick(0);
    end
    chk("t1_x20", x, 20);
    chk("t1_y", y, 0);
    chk("t1_no_ls", ls_d, 0);

    // Line-level timing at continuous pix_en
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < tbl[i].adv; k++) tick(1);
      chk($sformatf("v%0d_x", i), x, tbl[i].x);
      chk($sformatf("v%0d_y", i), y, tbl[i].y);
      chk($sformatf("v%0d_hs", i), hs, tbl[i].hs);
      chk($sformatf("v%0d_vs", i), vs, 1);
      chk($sformatf("v%0d_act", i), act, tbl[i].act);
      chk($sformatf("v%0d_ls", i), ls, tbl[i].ls);
      chk($sformatf("v%0d_fs", i), fs, 0);
    end

    hs_low_d = 0;
    repeat (800) tick(1);
    chk("line_x", x, 0); chk("line_y", y, 2); chk("line_ls", ls, 1);
    chk("hs_low_strobes", hs_low_d, 96);
    tick(0);
    chk("hold_ls_drop", ls, 0); chk("hold_x", x, 0); chk("hold_y", y, 2);

    // Whole frames on the small raster
    do_reset();
    tick(0);
    s_ls_n = 0; s_fs_n = 0; s_hs_n = 0; s_vs_n = 0; s_act_n = 0;
    last_fs = -1; fs_gap = 0; cyc = 0;
    repeat (329) tick(1);
    chk("s_pre_x", sx, 14); chk("s_pre_y", sy, 10);
    chk("s_pre_fs", s_fs, 0); chk("s_pre_act", s_act, 0);
    tick(1);
    chk("s_wrap_x", sx, 0); chk("s_wrap_y", sy, 0);
    chk("s_wrap_fs", s_fs, 1); chk("s_wrap_ls", s_ls, 1);
    chk("s_wrap_act", s_act, 1); chk("s_wrap_vs", s_vs, 0);
    tick(0);
    chk("s_fs_drop", s_fs, 0); chk("s_ls_drop", s_ls, 0);
    chk("s_ls_count", s_ls_n, 22);
    chk("s_fs_count", s_fs_n, 2);
    chk("s_fs_gap", fs_gap, 165);
    chk("s_vs_strobes", s_vs_n, 60);
    chk("s_hs_strobes", s_hs_n, 66);
    chk("s_act_strobes", s_act_n, 96);
    chk("d_x330", x, 330); chk("d_hs330", hs, 1); chk("d_act330", act, 1);

    // Vsync window edges on the small raster
    repeat (104) tick(1);
    chk("s_y6_x14", sx * 100 + sy, 1406); chk("s_y6_vs", s_vs, 0);
    tick(1);
    chk("s_y7_vs", s_vs, 1); chk("s_y7_ls", s_ls, 1);
    repeat (30) tick(1);
    chk("s_y9_y", sy, 9); chk("s_y9_vs", s_vs, 0);

    // Asynchronous reset mid-line/mid-frame
    #2 rst_n = 1'b0;
    #1;
    chk("arst_x", x, 0);     chk("arst_y", y, 0);
    chk("arst_sx", sx, 0);   chk("arst_sy", sy, 0);
    chk("arst_hs", hs, 1);   chk("arst_act", act, 1);
    chk("arst_s_vs", s_vs, 0); chk("arst_s_ls", s_ls, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(0);
    chk("arel_x", x, 0); chk("arel_ls", ls, 0);
    tick(1);
    chk("arel_x1", x, 1); chk("arel_y0", y, 0);
    chk("arel_sx1", sx, 1); chk("arel_sy0", sy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
